// File: rtl/aes_ctrl_pkg.sv
// aes_ctrl_pkg: register offsets, CTRL/STATUS bit positions and FSM encoding for aes_wb_ctrl
package aes_ctrl_pkg;
  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_KEY    = 8'h10;
  localparam logic [7:0] OFF_BLK    = 8'h20;
  localparam logic [7:0] OFF_RES    = 8'h30;
  localparam int CTRL_INIT    = 0;
  localparam int CTRL_NEXT    = 1;
  localparam int CTRL_ENCDEC  = 2;
  localparam int CTRL_IRQ_EN  = 3;
  localparam int ST_BUSY      = 0;
  localparam int ST_DONE      = 1;
  localparam int ST_ERR       = 2;
  localparam int ST_KEY_VALID = 3;
  typedef enum logic [2:0] {IDLE, KEY_INIT, KEY_WAIT, BLK_START, BLK_WAIT, DONE} state_t;
  function automatic logic [31:0] byte_merge(input logic [31:0] cur, input logic [31:0] nxt, input logic [3:0] sel);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sel[i] ? nxt[8*i +: 8] : cur[8*i +: 8];
    return r;
  endfunction
endpackage

// File: rtl/aes_wb_regif.sv
// aes_wb_regif: Wishbone decode, single-cycle ack and byte-enabled register file for aes_wb_ctrl
module aes_wb_regif
  import aes_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stb,
  input  logic             cyc,
  input  logic             we,
  input  logic [3:0]       sel,
  input  logic [31:0]      adr,
  input  logic [31:0]      dat_in,
  output logic             ack,
  output logic [31:0]      dat_out,
  input  logic             busy,
  input  logic             key_valid,
  input  logic             done,
  input  logic             err,
  input  logic [3:0][31:0] res,
  output logic [3:0][31:0] key,
  output logic [3:0][31:0] blk,
  output logic             encdec,
  output logic             irq_en,
  output logic             init_req,
  output logic             next_req,
  output logic             clr_done,
  output logic             clr_err,
  output logic             key_wr
);
  logic [7:0] off;
  logic [1:0] w;
  logic acc, wr, cfg_wr, is_ctrl, is_stat, is_key, is_blk, is_res, unused;
  logic [31:0] rdata;
  assign unused = ^adr[1:0];
  assign off = {adr[7:2], 2'b00};
  assign w = off[3:2];
  // ~ack keeps a held strobe from being acked on back-to-back cycles
  assign acc = stb & cyc & ~ack & (adr[31:8] == BASE_ADR[31:8]);
  assign wr = acc & we;
  assign cfg_wr = wr & ~busy;
  assign is_ctrl = off == OFF_CTRL;
  assign is_stat = off == OFF_STATUS;
  assign is_key = off[7:4] == OFF_KEY[7:4];
  assign is_blk = off[7:4] == OFF_BLK[7:4];
  assign is_res = off[7:4] == OFF_RES[7:4];
  assign init_req = cfg_wr & is_ctrl & sel[0] & dat_in[CTRL_INIT];
  assign next_req = cfg_wr & is_ctrl & sel[0] & dat_in[CTRL_NEXT];
  assign clr_done = wr & is_stat & sel[0] & dat_in[ST_DONE];
  assign clr_err = wr & is_stat & sel[0] & dat_in[ST_ERR];
  assign key_wr = cfg_wr & is_key;
  // word 0 sits in the top 32 bits, so packed index is the inverted word number
  always_comb begin
    rdata = '0;
    if (is_ctrl) begin
      rdata[CTRL_ENCDEC] = encdec;
      rdata[CTRL_IRQ_EN] = irq_en;
    end
    if (is_stat) begin
      rdata[ST_BUSY] = busy;
      rdata[ST_DONE] = done;
      rdata[ST_ERR] = err;
      rdata[ST_KEY_VALID] = key_valid;
    end
    if (is_key) rdata = key[~w];
    if (is_blk) rdata = blk[~w];
    if (is_res) rdata = res[~w];
  end
  always_ff @(posedge clk)
    if (rst) begin
      ack <= 1'b0;
      dat_out <= '0;
      key <= '0;
      blk <= '0;
      encdec <= 1'b0;
      irq_en <= 1'b0;
    end else begin
      ack <= acc;
      dat_out <= acc & ~we ? rdata : '0;
      if (cfg_wr & is_key) key[~w] <= byte_merge(key[~w], dat_in, sel);
      if (cfg_wr & is_blk) blk[~w] <= byte_merge(blk[~w], dat_in, sel);
      if (cfg_wr & is_ctrl & sel[0]) begin
        encdec <= dat_in[CTRL_ENCDEC];
        irq_en <= dat_in[CTRL_IRQ_EN];
      end
    end
endmodule

// File: rtl/aes_wb_ctrl.sv
// aes_wb_ctrl: Wishbone-mapped control FSM sequencing key expansion and block processing on an AES core
module aes_wb_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADR = 32'h3000_0000,
  parameter logic [15:0] TIMEOUT  = 16'd1023
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic         wbs_stb_i,
  input  logic         wbs_cyc_i,
  input  logic         wbs_we_i,
  input  logic [3:0]   wbs_sel_i,
  input  logic [31:0]  wbs_adr_i,
  input  logic [31:0]  wbs_dat_i,
  output logic         wbs_ack_o,
  output logic [31:0]  wbs_dat_o,
  output logic [127:0] aes_key_o,
  output logic [127:0] aes_block_o,
  output logic         aes_encdec_o,
  output logic         aes_init_o,
  output logic         aes_next_o,
  input  logic         aes_ready_i,
  input  logic [127:0] aes_result_i,
  input  logic         aes_result_valid_i,
  output logic         irq_o
);
  state_t state;
  logic [15:0] cnt;
  logic [127:0] res;
  logic chain, key_valid, done, err, busy, tmo;
  logic irq_en, init_req, next_req, clr_done, clr_err, key_wr;
  assign busy = state != IDLE;
  assign tmo = cnt == TIMEOUT - 16'd1;
  aes_wb_regif #(.BASE_ADR(BASE_ADR)) u_regif (
    .clk(wb_clk_i), .rst(wb_rst_i), .stb(wbs_stb_i), .cyc(wbs_cyc_i), .we(wbs_we_i),
    .sel(wbs_sel_i), .adr(wbs_adr_i), .dat_in(wbs_dat_i), .ack(wbs_ack_o), .dat_out(wbs_dat_o),
    .busy(busy), .key_valid(key_valid), .done(done), .err(err), .res(res),
    .key(aes_key_o), .blk(aes_block_o), .encdec(aes_encdec_o), .irq_en(irq_en),
    .init_req(init_req), .next_req(next_req), .clr_done(clr_done), .clr_err(clr_err), .key_wr(key_wr)
  );
  // core pulses are raised on entry so they coincide with KEY_INIT / BLK_START
  always_ff @(posedge wb_clk_i)
    if (wb_rst_i) begin
      state <= IDLE;
      cnt <= '0;
      chain <= 1'b0;
      key_valid <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      res <= '0;
      aes_init_o <= 1'b0;
      aes_next_o <= 1'b0;
      irq_o <= 1'b0;
    end else begin
      aes_init_o <= 1'b0;
      aes_next_o <= 1'b0;
      irq_o <= irq_en & (done | err);
      if (clr_done) done <= 1'b0;
      if (clr_err) err <= 1'b0;
      if (key_wr) key_valid <= 1'b0;
      case (state)
        IDLE:
          if (init_req) begin
            state <= KEY_INIT;
            aes_init_o <= 1'b1;
            chain <= next_req;
          end else if (next_req & key_valid) begin
            state <= BLK_START;
            aes_next_o <= 1'b1;
          end else if (next_req) err <= 1'b1;
        KEY_INIT: begin
          state <= KEY_WAIT;
          cnt <= '0;
        end
        KEY_WAIT:
          if (aes_ready_i) begin
            key_valid <= 1'b1;
            state <= chain ? BLK_START : IDLE;
            aes_next_o <= chain;
          end else if (tmo) begin
            err <= 1'b1;
            key_valid <= 1'b0;
            state <= IDLE;
          end else cnt <= cnt + 16'd1;
        BLK_START: begin
          state <= BLK_WAIT;
          cnt <= '0;
        end
        BLK_WAIT:
          if (aes_result_valid_i) begin
            res <= aes_result_i;
            state <= DONE;
          end else if (tmo) begin
            err <= 1'b1;
            key_valid <= 1'b0;
            state <= IDLE;
          end else cnt <= cnt + 16'd1;
        DONE: begin
          done <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_aes_wb_ctrl.sv
// tb_aes_wb_ctrl: directed and randomized bench with a behavioural core model and register-level reference model
module tb_aes_wb_ctrl;
  import aes_ctrl_pkg::*;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [15:0] TMO = 16'd40;
  localparam logic [127:0] KEY_V = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_V = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_V = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  logic clk = 0, rst = 1, stb = 0, cyc = 0, we = 0;
  logic [3:0] sel = 0;
  logic [31:0] adr = 0, wdat = 0, rdat;
  logic ack, enc_o, init_o, next_o, irq;
  logic [127:0] key_o, blk_o, result = 0, pend_res = 0;
  logic ready = 1, valid = 0;
  int total = 0, bad = 0, n_init = 0, n_next = 0, lat = 0, lat_min = 1, lat_max = 6;
  int i0, n0, exp_init, exp_next;
  bit hang = 0, pend = 0;
  logic [127:0] m_key = 0, m_blk = 0, m_res = 0;
  logic m_enc = 0, m_irq_en = 0, m_kv = 0, m_done = 0, m_err = 0;
  logic [31:0] q;
  logic a1, a2, a3, ok;

  always #5 clk = ~clk;

  aes_wb_ctrl #(.BASE_ADR(BASE), .TIMEOUT(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .aes_key_o(key_o), .aes_block_o(blk_o), .aes_encdec_o(enc_o), .aes_init_o(init_o),
    .aes_next_o(next_o), .aes_ready_i(ready), .aes_result_i(result),
    .aes_result_valid_i(valid), .irq_o(irq)
  );

  // stand-in cipher: known vectors both ways, a reversible mix otherwise
  function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] b, input logic e);
    if (k == KEY_V && b == PT_V && e) return CT_V;
    if (k == KEY_V && b == CT_V && !e) return PT_V;
    return b ^ {k[63:0], k[127:64]} ^ {128{e}};
  endfunction

  function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? n[8*b +: 8] : o[8*b +: 8];
    return r;
  endfunction

  initial forever begin
    @(negedge clk);
    valid = 0;
    if (init_o) begin
      n_init++;
      ready = 0;
      lat = int'($urandom_range(lat_max, lat_min));
    end else if (next_o) begin
      n_next++;
      ready = 0;
      lat = int'($urandom_range(lat_max, lat_min));
      pend = 1;
      pend_res = core_fn(key_o, blk_o, enc_o);
    end else if (!ready && !hang) begin
      if (lat == 0) begin
        ready = 1;
        if (pend) begin
          valid = 1;
          result = pend_res;
          pend = 0;
        end
      end else lat--;
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, obs, expv);
    end
  endtask

  task automatic bus(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] rq, output logic rok);
    @(negedge clk);
    adr = a; we = w; wdat = d; sel = s; stb = 1; cyc = 1;
    rok = 0; rq = 0;
    for (int i = 0; i < 8 && !rok; i++) begin
      @(negedge clk);
      if (ack) begin
        rok = 1;
        rq = rdat;
      end
    end
    stb = 0; cyc = 0; we = 0;
  endtask

  task automatic reg_wr(input logic [7:0] off, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] t;
    logic k;
    bus(BASE | {24'd0, off}, 1, d, s, t, k);
    chk("wr_ack", k, 1);
  endtask

  task automatic reg_rd(input logic [7:0] off, output logic [31:0] d);
    logic k;
    bus(BASE | {24'd0, off}, 0, 0, 4'hf, d, k);
    chk("rd_ack", k, 1);
  endtask

  task automatic set_key(input int i, input logic [31:0] d, input logic [3:0] s);
    reg_wr(OFF_KEY + 8'(4*i), d, s);
    m_key[127-32*i -: 32] = mrg(m_key[127-32*i -: 32], d, s);
    m_kv = 0;
  endtask

  task automatic set_blk(input int i, input logic [31:0] d, input logic [3:0] s);
    reg_wr(OFF_BLK + 8'(4*i), d, s);
    m_blk[127-32*i -: 32] = mrg(m_blk[127-32*i -: 32], d, s);
  endtask

  task automatic wait_idle();
    logic [31:0] t;
    logic idle = 0;
    for (int i = 0; i < 100 && !idle; i++) begin
      reg_rd(OFF_STATUS, t);
      idle = !t[ST_BUSY];
    end
    chk("idle_timeout", idle, 1);
  endtask

  task automatic check_all(input string tag);
    logic [31:0] t;
    reg_rd(OFF_STATUS, t);
    chk({tag, ":status"}, t, {28'd0, m_kv, m_err, m_done, 1'b0});
    reg_rd(OFF_CTRL, t);
    chk({tag, ":ctrl"}, t, {28'd0, m_irq_en, m_enc, 2'b00});
    for (int i = 0; i < 4; i++) begin
      reg_rd(OFF_RES + 8'(4*i), t);
      chk({tag, ":res"}, t, m_res[127-32*i -: 32]);
    end
    chk({tag, ":irq"}, irq, m_irq_en & (m_done | m_err));
  endtask

  task automatic ctrl_go(input logic [3:0] d);
    reg_wr(OFF_CTRL, {28'd0, d}, 4'hf);
    m_enc = d[2];
    m_irq_en = d[3];
    exp_init = d[0] ? 1 : 0;
    exp_next = (d[1] && (d[0] || m_kv)) ? 1 : 0;
    if (d[0]) m_kv = 1;
    if (d[1]) begin
      if (m_kv) begin
        m_res = core_fn(m_key, m_blk, m_enc);
        m_done = 1;
      end else m_err = 1;
    end
  endtask

  task automatic run_ctrl(input string tag, input logic [3:0] d, input bit poke);
    i0 = n_init;
    n0 = n_next;
    ctrl_go(d);
    if (poke) reg_wr(OFF_BLK, 32'hFFFF_FFFF, 4'hf);
    wait_idle();
    check_all(tag);
    chk({tag, ":init_pulses"}, 32'(n_init - i0), 32'(exp_init));
    chk({tag, ":next_pulses"}, 32'(n_next - n0), 32'(exp_next));
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, ":ack"}, ack, 0);
    chk({tag, ":dat"}, rdat, 0);
    chk({tag, ":key"}, key_o, 0);
    chk({tag, ":blk"}, blk_o, 0);
    chk({tag, ":enc"}, enc_o, 0);
    chk({tag, ":init"}, init_o, 0);
    chk({tag, ":next"}, next_o, 0);
    chk({tag, ":irq"}, irq, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rst = 0;
    check_all("reset");
    // NEXT with no valid key is an error and must not reach the core
    run_ctrl("next_nokey", 4'h2, 0);
    reg_wr(OFF_STATUS, 32'h4, 4'hf);
    m_err = 0;
    check_all("err_w1c");
    // decode boundaries
    bus(BASE + 32'h100, 0, 0, 4'hf, q, ok);
    chk("unclaimed_noack", ok, 0);
    bus(BASE - 32'h4, 1, 32'h1234, 4'hf, q, ok);
    chk("below_window_noack", ok, 0);
    reg_rd(8'h08, q);
    chk("unmapped_08", q, 0);
    reg_rd(8'h40, q);
    chk("unmapped_40", q, 0);
    reg_rd(8'hFC, q);
    chk("unmapped_fc", q, 0);
    @(negedge clk);
    adr = BASE | {24'd0, OFF_STATUS}; we = 0; sel = 4'hf; stb = 1; cyc = 1;
    @(negedge clk); a1 = ack;
    @(negedge clk); a2 = ack;
    @(negedge clk); a3 = ack;
    stb = 0; cyc = 0;
    chk("held_stb_ack_seq", {a1, a2, a3}, 3'b101);
    // known-answer encrypt then decrypt with the expanded key
    for (int i = 0; i < 4; i++) set_key(i, KEY_V[127-32*i -: 32], 4'hf);
    for (int i = 0; i < 4; i++) set_blk(i, PT_V[127-32*i -: 32], 4'hf);
    run_ctrl("encrypt_kat", 4'h7, 0);
    reg_rd(OFF_RES, q);
    chk("encrypt_res0", q, 32'h69c4e0d8);
    reg_rd(OFF_RES + 8'hC, q);
    chk("encrypt_res3", q, 32'h70b4c55a);
    for (int i = 0; i < 4; i++) set_blk(i, CT_V[127-32*i -: 32], 4'hf);
    run_ctrl("decrypt_kat", 4'h2, 0);
    reg_rd(OFF_RES + 8'h4, q);
    chk("decrypt_res1", q, 32'h44556677);
    // writes while busy are dropped; partial byte enables merge
    reg_wr(OFF_STATUS, 32'h6, 4'hf);
    m_done = 0; m_err = 0;
    lat_min = 20; lat_max = 20;
    run_ctrl("busy_write", 4'h7, 1);
    reg_rd(OFF_BLK, q);
    chk("blk0_busy_unchanged", q, m_blk[127:96]);
    set_blk(0, 32'hA5A5_A5A5, 4'b0010);
    reg_rd(OFF_BLK, q);
    chk("blk0_sel_byte1", q, m_blk[127:96]);
    lat_min = 1; lat_max = 6;
    // key expansion never completes: timeout boundary observed through irq
    reg_wr(OFF_STATUS, 32'h6, 4'hf);
    m_done = 0; m_err = 0;
    hang = 1;
    reg_wr(OFF_CTRL, 32'h9, 4'hf);
    m_enc = 0; m_irq_en = 1;
    repeat (int'(TMO) + 1) @(negedge clk);
    chk("timeout_irq_before", irq, 0);
    @(negedge clk);
    chk("timeout_irq_after", irq, 1);
    m_kv = 0; m_err = 1;
    check_all("timeout");
    hang = 0;
    repeat (10) @(negedge clk);
    // randomized traffic against the register-level model
    for (int it = 0; it < 10; it++) begin
      int op, k;
      reg_wr(OFF_STATUS, 32'h6, 4'hf);
      m_done = 0; m_err = 0;
      if ($urandom_range(1, 0) == 1)
        for (int i = 0; i < 4; i++) set_key(i, $urandom, 4'($urandom_range(15, 1)));
      for (int i = 0; i < 4; i++) set_blk(i, $urandom, 4'($urandom_range(15, 1)));
      k = int'($urandom_range(3, 0));
      reg_rd(OFF_KEY + 8'(4*k), q);
      chk("rand_key_rd", q, m_key[127-32*k -: 32]);
      k = int'($urandom_range(3, 0));
      reg_rd(OFF_BLK + 8'(4*k), q);
      chk("rand_blk_rd", q, m_blk[127-32*k -: 32]);
      op = int'($urandom_range(2, 0));
      run_ctrl("rand_op", {1'($urandom), 1'($urandom), op == 0 ? 2'b11 : op == 1 ? 2'b10 : 2'b01}, 0);
    end
    // reset while waiting for a block result; the late result must be ignored
    run_ctrl("pre_reset_init", 4'h1, 0);
    lat_min = 12; lat_max = 12;
    reg_wr(OFF_CTRL, 32'h2, 4'hf);
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk_outputs_zero("mid_reset");
    @(negedge clk);
    rst = 0;
    m_key = 0; m_blk = 0; m_res = 0; m_enc = 0; m_irq_en = 0; m_kv = 0; m_done = 0; m_err = 0;
    repeat (20) @(negedge clk);
    check_all("post_reset");
    reg_rd(OFF_KEY, q);
    chk("post_reset_key0", q, 0);
    reg_rd(OFF_BLK + 8'hC, q);
    chk("post_reset_blk3", q, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/aes_wb_ctrl.md
AES_WB_CTRL -- requirements
Module: aes_wb_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADR, default 32'h3000_0000: Wishbone window base; the block claims addresses whose bits [31:8] equal BASE_ADR[31:8].
REQ-002 SHALL have parameter TIMEOUT, default 16'd1023: maximum cycles spent in any core-wait state before an error is raised.
REQ-003 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-004 wb_clk_i  in  1  clock for all logic.
REQ-005 wb_rst_i  in  1  synchronous active-high reset.
REQ-006 wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone strobe, cycle and write-enable.
REQ-007 wbs_sel_i  in  4  byte enables; wbs_adr_i  in  32  address; wbs_dat_i  in  32  write data.
REQ-008 wbs_ack_o  out  1  acknowledge; wbs_dat_o  out  32  read data.
REQ-009 aes_key_o  out  128  key to core; aes_block_o  out  128  input block; aes_encdec_o  out  1  1=encrypt.
REQ-010 aes_init_o, aes_next_o  out  1 each  single-cycle key-expansion and block-start pulses.
REQ-011 aes_ready_i  in  1  core idle; aes_result_i  in  128  result; aes_result_valid_i  in  1  result valid.
REQ-012 irq_o  out  1  level interrupt.

Function
REQ-013 Register map (byte offsets): 0x00 CTRL (bit0 INIT, bit1 NEXT, bit2 ENCDEC, bit3 IRQ_EN); 0x04 STATUS (bit0 BUSY RO, bit1 DONE W1C, bit2 ERR W1C, bit3 KEY_VALID RO); 0x10-0x1C KEY0..3; 0x20-0x2C BLK0..3; 0x30-0x3C RES0..3 RO. Word 0 maps to bits [127:96].
REQ-014 Wishbone: wbs_ack_o is asserted for exactly one cycle, one cycle after a stb&cyc on a claimed address, and is deasserted for at least one cycle between acks; unclaimed addresses are never acked.
REQ-015 Writes honour wbs_sel_i per byte; reads of unmapped offsets inside the window return 0 and are acked.
REQ-016 INIT and NEXT are self-clearing and always read as 0.
REQ-017 FSM states: IDLE, KEY_INIT, KEY_WAIT, BLK_START, BLK_WAIT, DONE.
REQ-018 IDLE: INIT written -> KEY_INIT; NEXT written with KEY_VALID=1 -> BLK_START; NEXT written with KEY_VALID=0 -> ERR set, remain in IDLE.
REQ-019 KEY_INIT drives aes_init_o for one cycle -> KEY_WAIT; KEY_WAIT on aes_ready_i sets KEY_VALID, then goes to BLK_START if NEXT was written together with INIT, otherwise to IDLE.
REQ-020 BLK_START drives aes_next_o for one cycle -> BLK_WAIT; BLK_WAIT on aes_result_valid_i captures aes_result_i into RES -> DONE.
REQ-021 DONE sets the DONE bit for one cycle -> IDLE.
REQ-022 BUSY = 1 in every state except IDLE.
REQ-023 A 16-bit wait counter clears on entry to KEY_WAIT and BLK_WAIT; if it reaches TIMEOUT, ERR is set, KEY_VALID is cleared and the FSM returns to IDLE.
REQ-024 Writes to KEY, BLK or CTRL while BUSY=1 are acked and have no effect; writing KEY clears KEY_VALID when idle.
REQ-025 irq_o = IRQ_EN & (DONE | ERR), registered.
REQ-026 aes_key_o, aes_block_o and aes_encdec_o are driven directly from their registers.

Reset
REQ-027 On wb_rst_i all registers are 0, the FSM is in IDLE, and wbs_ack_o, wbs_dat_o, aes_init_o, aes_next_o and irq_o are 0.
REQ-028 A reset asserted mid-operation aborts the operation in the next cycle; any late aes_result_valid_i is ignored.

Structure
REQ-029 Package aes_ctrl_pkg holds the register offsets, CTRL/STATUS bit positions and the FSM state encoding.
REQ-030 One sub-module, aes_wb_regif, performs Wishbone decode, ack generation and byte-enable register writes; the FSM lives in aes_wb_ctrl.

Verification
REQ-031 Encrypt vector: write KEY=000102030405060708090a0b0c0d0e0f and BLK=00112233445566778899aabbccddeeff, then write CTRL=0x7 -> DONE=1 and RES=69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-032 After REQ-031, write ENCDEC=0, BLK=69c4e0d8..., and NEXT only -> RES=00112233445566778899aabbccddeeff with no aes_init_o pulse.
REQ-033 NEXT written after reset (KEY_VALID=0) -> ERR=1, no aes_next_o pulse; writing STATUS=0x4 clears ERR.
REQ-034 Core model holds aes_ready_i low -> ERR is set after exactly TIMEOUT cycles, BUSY=0, and irq_o=1 when IRQ_EN=1.
REQ-035 Write BLK0=0xFFFFFFFF while BUSY -> BLK0 unchanged; write with sel=4'b0010 -> only byte [15:8] updated.
REQ-036 Assert wb_rst_i during BLK_WAIT -> all outputs 0 in the next cycle and RES stays 0 after a late aes_result_valid_i.
